// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: two-entry (output reg + skid) buffer with a registered branch redirect.
// Optional perf counters are enabled with `define EX_MEM_PERF_EN.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_ex,
    input  logic            flush_ex,
    input  logic            alu_ready,
    input  logic [XLEN-1:0] alu_result_ex,
    input  logic            branch_alu,
    input  logic            jalr_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] src_a_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] store_data_ex,
    input  logic [RD_W-1:0] rd_ex,
    input  logic            reg_write_ex,
    input  logic            mem_read_ex,
    input  logic            mem_write_ex,
    input  logic            data_ready_mem,
    output logic            stall_ex,
    output logic            valid_mem,
    output logic [XLEN-1:0] alu_result_mem,
    output logic [XLEN-1:0] store_data_mem,
    output logic [RD_W-1:0] rd_mem,
    output logic            reg_write_mem,
    output logic            mem_read_mem,
    output logic            mem_write_mem,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef EX_MEM_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_branch_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sd;
        logic [RD_W-1:0] rd;
        logic            rw;
        logic            mr;
        logic            mw;
    } entry_t;

    logic [1:0]      state;
    entry_t          out_q;
    entry_t          skid_q;
    entry_t          in_e;
    logic            accept;
    logic            pop;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    always_comb begin
        in_e     = '0;
        in_e.res = alu_result_ex;
        in_e.sd  = store_data_ex;
        in_e.rd  = rd_ex;
        in_e.rw  = reg_write_ex;
        in_e.mr  = mem_read_ex;
        in_e.mw  = mem_write_ex;
    end

    assign accept   = valid_ex & alu_ready & ~flush_ex & (state != FULL);
    assign pop      = valid_mem & data_ready_mem;
    assign stall_ex = valid_ex & ~flush_ex & (~alu_ready | (state == FULL));

    assign jalr_sum = src_a_ex + imm_ex;
    assign target   = jalr_ex ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_ex + imm_ex);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q <= in_e;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_q <= in_e;
                    end else if (accept) begin
                        skid_q <= in_e;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_q <= skid_q;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= accept & branch_alu;
            if (accept && branch_alu) begin
                redirect_pc <= target;
            end
        end
    end

    assign valid_mem      = (state != EMPTY);
    assign alu_result_mem = out_q.res;
    assign store_data_mem = out_q.sd;
    assign rd_mem         = out_q.rd;
    // Control bits are gated so a stale out reg never looks like a live write.
    assign reg_write_mem  = out_q.rw & valid_mem;
    assign mem_read_mem   = out_q.mr & valid_mem;
    assign mem_write_mem  = out_q.mw & valid_mem;

`ifdef EX_MEM_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_branch_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (redirect && (perf_branch_cnt != '1)) begin
                perf_branch_cnt <= perf_branch_cnt + 1'b1;
            end
            if (stall_ex && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_ex, flush_ex, alu_ready, branch_alu, jalr_ex, data_ready_mem;
    logic [31:0] alu_result_ex, pc_ex, src_a_ex, imm_ex, store_data_ex;
    logic [4:0]  rd_ex;
    logic        reg_write_ex, mem_read_ex, mem_write_ex;
    logic        stall_ex, valid_mem, reg_write_mem, mem_read_mem, mem_write_mem, redirect;
    logic [31:0] alu_result_mem, store_data_mem, redirect_pc;
    logic [4:0]  rd_mem;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_branch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(32), .RD_W(5), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .valid_ex(valid_ex), .flush_ex(flush_ex), .alu_ready(alu_ready),
        .alu_result_ex(alu_result_ex), .branch_alu(branch_alu), .jalr_ex(jalr_ex), .pc_ex(pc_ex),
        .src_a_ex(src_a_ex), .imm_ex(imm_ex), .store_data_ex(store_data_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .data_ready_mem(data_ready_mem), .stall_ex(stall_ex), .valid_mem(valid_mem),
        .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem), .rd_mem(rd_mem),
        .reg_write_mem(reg_write_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef EX_MEM_PERF_EN
        , .perf_branch_cnt(perf_branch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } ent_t;

    ent_t        q[$];
    logic        exp_redirect;
    logic [31:0] exp_rpc;
    longint      exp_bcnt, exp_scnt;
    int          tests, fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_target();
        longint t;
        if (jalr_ex) begin
            t = (longint'(src_a_ex) + longint'(imm_ex)) % 64'h1_0000_0000;
            t = t - (t % 2);
        end else begin
            t = (longint'(pc_ex) + longint'(imm_ex)) % 64'h1_0000_0000;
        end
        return t[31:0];
    endfunction

    task automatic idle();
        valid_ex = 0; flush_ex = 0; alu_ready = 1; branch_alu = 0; jalr_ex = 0;
        data_ready_mem = 1; alu_result_ex = '0; pc_ex = '0; src_a_ex = '0; imm_ex = '0;
        store_data_ex = '0; rd_ex = '0; reg_write_ex = 0; mem_read_ex = 0; mem_write_ex = 0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_redirect = 0; exp_rpc = '0; exp_bcnt = 0; exp_scnt = 0;
    endtask

    task automatic check_outputs();
        logic exp_stall;
        exp_stall = valid_ex & ~flush_ex & (~alu_ready | (q.size() == 2));
        chk("stall_ex", stall_ex, exp_stall);
        chk("valid_mem", valid_mem, q.size() != 0);
        if (q.size() != 0) begin
            chk("alu_result_mem", alu_result_mem, q[0].res);
            chk("store_data_mem", store_data_mem, q[0].sd);
            chk("rd_mem", rd_mem, q[0].rd);
            chk("reg_write_mem", reg_write_mem, q[0].rw);
            chk("mem_read_mem", mem_read_mem, q[0].mr);
            chk("mem_write_mem", mem_write_mem, q[0].mw);
        end else begin
            chk("ctrl_empty", {reg_write_mem, mem_read_mem, mem_write_mem}, 0);
        end
        chk("redirect", redirect, exp_redirect);
        if (exp_redirect) chk("redirect_pc", redirect_pc, exp_rpc);
`ifdef EX_MEM_PERF_EN
        chk("perf_branch_cnt", perf_branch_cnt, exp_bcnt);
        chk("perf_stall_cnt", perf_stall_cnt, exp_scnt);
`endif
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle();
        logic acc, pp;
        ent_t e;
        #1;
        check_outputs();
        acc = valid_ex & alu_ready & ~flush_ex & (q.size() < 2);
        pp  = (q.size() > 0) & data_ready_mem;
        @(posedge clk);
        if (exp_redirect && exp_bcnt < 64'hFFFF_FFFF) exp_bcnt++;
        if (valid_ex & ~flush_ex & (~alu_ready | (q.size() == 2)) && exp_scnt < 64'hFFFF_FFFF) exp_scnt++;
        if (pp) void'(q.pop_front());
        if (acc) begin
            e.res = alu_result_ex; e.sd = store_data_ex; e.rd = rd_ex;
            e.rw = reg_write_ex; e.mr = mem_read_ex; e.mw = mem_write_ex;
            q.push_back(e);
        end
        exp_redirect = acc & branch_alu;
        if (exp_redirect) exp_rpc = ref_target();
        @(negedge clk);
    endtask

    initial begin
        int stall_seen;
        tests = 0; fails = 0;
        idle();
        model_reset();
        rstn = 0;
        #1;
        chk("reset_valid", valid_mem, 0);
        chk("reset_redirect", redirect, 0);
        chk("reset_result", alu_result_mem, 0);
        chk("reset_ctrl", {reg_write_mem, mem_read_mem, mem_write_mem}, 0);
        @(negedge clk); @(negedge clk);
        rstn = 1;

        // Back-to-back accepts with MEM always ready.
        for (int k = 1; k <= 4; k++) begin
            valid_ex = 1; alu_result_ex = 32'(k); rd_ex = 5'(k); reg_write_ex = 1;
            cycle();
            chk("b2b_result", alu_result_mem, k);
        end
        idle(); cycle(); cycle();

        // Backpressure: two held, third stalls, then drains in order.
        data_ready_mem = 0; valid_ex = 1;
        alu_result_ex = 32'hA; cycle();
        alu_result_ex = 32'hB; cycle();
        alu_result_ex = 32'hC; #1; chk("bp_stall_full", stall_ex, 1); cycle();
        chk("bp_head", alu_result_mem, 32'hA);
        data_ready_mem = 1; cycle();
        chk("bp_second", alu_result_mem, 32'hB);
        cycle();
        chk("bp_third", alu_result_mem, 32'hC);
        idle(); cycle(); cycle();

        // FPU wait: five stalled cycles then accept.
        valid_ex = 1; alu_ready = 0; alu_result_ex = 32'h55; stall_seen = 0;
        for (int k = 0; k < 5; k++) begin
            #1; if (stall_ex) stall_seen++;
            cycle();
        end
        chk("fpu_stall_cycles", stall_seen, 5);
        alu_ready = 1; cycle();
        chk("fpu_accept", {valid_mem, alu_result_mem}, {1'b1, 32'h55});
        idle(); cycle();

        // Branch and jalr redirect targets.
        valid_ex = 1; branch_alu = 1; pc_ex = 32'h100; imm_ex = 32'h20; cycle();
        chk("br_redirect", redirect, 1);
        chk("br_target", redirect_pc, 32'h120);
        jalr_ex = 1; src_a_ex = 32'h203; imm_ex = 32'h0; cycle();
        chk("jalr_target", redirect_pc, 32'h202);
        idle(); cycle();
        chk("redirect_pulse_end", redirect, 0);
        cycle();

        // Flush with a taken branch while FULL leaves the buffer untouched.
        data_ready_mem = 0; valid_ex = 1;
        alu_result_ex = 32'h11; cycle();
        alu_result_ex = 32'h22; cycle();
        flush_ex = 1; branch_alu = 1; alu_result_ex = 32'h33; pc_ex = 32'h400; cycle();
        chk("flush_no_redirect", redirect, 0);
        chk("flush_head", alu_result_mem, 32'h11);
        idle(); cycle(); cycle();

        // Async reset while FULL with a redirect pending.
        data_ready_mem = 0; valid_ex = 1;
        alu_result_ex = 32'h77; cycle();
        branch_alu = 1; pc_ex = 32'h800; imm_ex = 32'h4; alu_result_ex = 32'h88; cycle();
        chk("pre_reset_redirect", redirect, 1);
        idle();
        #2 rstn = 0;
        #1;
        chk("async_rst_valid", valid_mem, 0);
        chk("async_rst_redirect", redirect, 0);
`ifdef EX_MEM_PERF_EN
        chk("async_rst_perf", {perf_branch_cnt, perf_stall_cnt}, 0);
`endif
        model_reset();
        @(negedge clk); rstn = 1;

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            valid_ex       = ($urandom_range(0, 3) != 0);
            alu_ready      = ($urandom_range(0, 4) != 0);
            flush_ex       = ($urandom_range(0, 9) == 0);
            data_ready_mem = ($urandom_range(0, 4) < 3);
            branch_alu     = ($urandom_range(0, 3) == 0);
            jalr_ex        = $urandom_range(0, 1);
            alu_result_ex  = $urandom; store_data_ex = $urandom;
            pc_ex = $urandom; src_a_ex = $urandom; imm_ex = $urandom;
            rd_ex = 5'($urandom_range(0, 31));
            reg_write_ex = $urandom_range(0, 1);
            mem_read_ex  = $urandom_range(0, 1);
            mem_write_ex = $urandom_range(0, 1);
            cycle();
        end
        idle(); cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
